// File: rtl/arm_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
// Holds the access state encoding and the word-address helper used by the top level.
package arm_pkg;

    localparam int DATA_W = 32;
    localparam int SRAM_DW = 16;
    localparam logic [DATA_W-1:0] DEF_BASE_ADDR = 32'd1024;
    localparam int DEF_WAIT_CYCLES = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_LO,
        WR_HI,
        DONE
    } sram_state_t;

    // Byte address to 32-bit word index; wraps modulo 2^32 below the base.
    function automatic logic [DATA_W-1:0] sram_word(input logic [DATA_W-1:0] addr,
                                                    input logic [DATA_W-1:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/sram_wait_timer.sv
// Wait-state counter for one SRAM half-word access.
// Counts 0..WAIT_CYCLES-1 while enabled and flags the final cycle with 'last'.
module sram_wait_timer
    import arm_pkg::*;
#(
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // The counter self-wraps on the last cycle so consecutive halves need no extra clear.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = last ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last = (count_q == LAST_CNT);

endmodule

// File: rtl/sram_mem_controller.sv
// MEM-stage controller: splits a 32-bit load/store into two 16-bit SRAM accesses
// with programmable wait states and stalls the pipeline until the access completes.
module sram_mem_controller
    import arm_pkg::*;
#(
    parameter logic [DATA_W-1:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int SRAM_AW = 18
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_r_en,
    input  logic                 mem_w_en,
    input  logic [DATA_W-1:0]    address,
    input  logic [DATA_W-1:0]    write_data,
    output logic [DATA_W-1:0]    read_data,
    output logic                 ready,
    output logic                 freeze,
    output logic [SRAM_AW-1:0]   sram_addr,
    output logic [SRAM_DW-1:0]   sram_dq_out,
    input  logic [SRAM_DW-1:0]   sram_dq_in,
    output logic                 sram_dq_oe,
    output logic                 sram_we_n
);

    sram_state_t          state_q;
    logic [DATA_W-1:0]    read_data_q;
    logic                 ready_q;
    logic [SRAM_AW-1:0]   sram_addr_q;
    logic [SRAM_DW-1:0]   dq_out_q;
    logic                 dq_oe_q;

    logic                 busy;
    logic                 last;
    logic [DATA_W-1:0]    word;
    logic [SRAM_AW-1:0]   lo_addr;
    logic                 unused_word_bits;

    assign word             = sram_word(address, BASE_ADDR);
    assign lo_addr          = {word[SRAM_AW-2:0], 1'b0};
    assign unused_word_bits = ^word[DATA_W-1:SRAM_AW-1];

    assign busy = (state_q inside {RD_LO, RD_HI, WR_LO, WR_HI});

    sram_wait_timer #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (!busy),
        .enable(busy),
        .last  (last)
    );

    // Read wins over write when both enables are high; address and data are held by the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            read_data_q <= '0;
            ready_q     <= 1'b0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_r_en) begin
                        state_q     <= RD_LO;
                        sram_addr_q <= lo_addr;
                    end else if (mem_w_en) begin
                        state_q     <= WR_LO;
                        sram_addr_q <= lo_addr;
                        dq_out_q    <= write_data[15:0];
                        dq_oe_q     <= 1'b1;
                    end
                end
                RD_LO: begin
                    if (last) begin
                        state_q           <= RD_HI;
                        read_data_q[15:0] <= sram_dq_in;
                        sram_addr_q[0]    <= 1'b1;
                    end
                end
                RD_HI: begin
                    if (last) begin
                        state_q            <= DONE;
                        read_data_q[31:16] <= sram_dq_in;
                        ready_q            <= 1'b1;
                    end
                end
                WR_LO: begin
                    if (last) begin
                        state_q        <= WR_HI;
                        sram_addr_q[0] <= 1'b1;
                        dq_out_q       <= write_data[31:16];
                    end
                end
                WR_HI: begin
                    if (last) begin
                        state_q <= DONE;
                        dq_oe_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The strobe releases on the last cycle of each write half so address and data are held past it.
    assign sram_we_n = !((state_q == WR_LO || state_q == WR_HI) && !last);

    assign read_data   = read_data_q;
    assign ready       = ready_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign freeze      = (mem_r_en | mem_w_en) & ~ready_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Scoreboard testbench for sram_mem_controller: stimulus pushes expected completions,
// a negedge monitor pops and compares them against a word-level SRAM reference model.
module tb_sram_mem_controller;

    localparam int WAIT_CYCLES = 4;
    localparam int SRAM_AW     = 18;
    localparam int HALVES      = 1 << SRAM_AW;
    localparam int WORDS       = 1 << (SRAM_AW - 1);
    localparam int LATENCY     = 2 * WAIT_CYCLES + 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               mem_r_en = 1'b0;
    logic               mem_w_en = 1'b0;
    logic [31:0]        address = '0;
    logic [31:0]        write_data = '0;
    logic [31:0]        read_data;
    logic               ready;
    logic               freeze;
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_out;
    logic [15:0]        sram_dq_in;
    logic               sram_dq_oe;
    logic               sram_we_n;

    sram_mem_controller #(
        .BASE_ADDR  (32'd1024),
        .WAIT_CYCLES(WAIT_CYCLES),
        .SRAM_AW    (SRAM_AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .freeze     (freeze),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_in (sram_dq_in),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural asynchronous SRAM: combinational read, write latched while the strobe is low.
    logic [15:0] sram_mem [0:HALVES-1];
    assign sram_dq_in = sram_mem[sram_addr];

    always @(posedge clk) begin
        if (rst_n && !sram_we_n) begin
            sram_mem[sram_addr] = sram_dq_oe ? sram_dq_out : 16'hFFFF;
        end
    end

    typedef struct {
        bit          is_write;
        int unsigned half_base;
        logic [31:0] data;
        logic [31:0] hold;
        int unsigned due;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] last_read = '0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int          we_low = 0;
    int          oe_high = 0;

    function automatic logic [15:0] init_half(input int unsigned h);
        return 16'((h * 32'd40503) ^ 32'h5A3C);
    endfunction

    function automatic int unsigned ref_word(input logic [31:0] a);
        logic [31:0] w;
        w = (a - 32'd1024) / 4;
        return w % WORDS;
    endfunction

    function automatic logic [31:0] ref_get(input int unsigned w);
        if (ref_mem.exists(w)) return ref_mem[w];
        return {init_half(2 * w + 1), init_half(2 * w)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%h, required 0x%h", name, cyc, act, exp_v);
        end
    endtask

    // Monitor: ready must pulse exactly on the cycle the scoreboard head is due.
    always @(negedge clk) begin
        bit   exp_ready;
        exp_t e;
        if (rst_n) begin
            exp_ready = (sbq.size() > 0) && (sbq[0].due == cyc);
            if (!sram_we_n) we_low++;
            if (sram_dq_oe) oe_high++;
            checkOutput("ready", 32'(ready), 32'(exp_ready));
            checkOutput("freeze", 32'(freeze), 32'((mem_r_en | mem_w_en) & ~exp_ready));
            if (exp_ready) begin
                e = sbq.pop_front();
                if (e.is_write) begin
                    checkOutput("wr_lo_half", 32'(sram_mem[e.half_base]), 32'(e.data[15:0]));
                    checkOutput("wr_hi_half", 32'(sram_mem[e.half_base + 1]), 32'(e.data[31:16]));
                    checkOutput("rd_hold_on_write", read_data, e.hold);
                    checkOutput("we_n_low_cycles", 32'(we_low), 32'(2 * (WAIT_CYCLES - 1)));
                    checkOutput("dq_oe_cycles", 32'(oe_high), 32'(2 * WAIT_CYCLES));
                end else begin
                    checkOutput("read_data", read_data, e.data);
                    checkOutput("read_we_n_low_cycles", 32'(we_low), 32'd0);
                    checkOutput("read_dq_oe_cycles", 32'(oe_high), 32'd0);
                end
                we_low  = 0;
                oe_high = 0;
            end
        end
    end

    task automatic idle(input int n);
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issues one access and returns in the cycle its ready pulse is due; b2b means the
    // previous access is in DONE right now, costing one extra IDLE cycle.
    task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                                 input logic [31:0] data, input bit b2b);
        exp_t        e;
        int unsigned w;
        int unsigned start;
        w          = ref_word(addr);
        mem_r_en   = rd;
        mem_w_en   = wr;
        address    = addr;
        write_data = data;
        start      = cyc + 1 + (b2b ? 1 : 0);
        e.is_write  = !rd;
        e.half_base = 2 * w;
        e.due       = cyc + LATENCY + (b2b ? 1 : 0);
        if (rd) begin
            e.data    = ref_get(w);
            e.hold    = '0;
            last_read = e.data;
        end else begin
            ref_mem[w] = data;
            e.data     = data;
            e.hold     = last_read;
        end
        sbq.push_back(e);
        while (cyc < e.due) begin
            @(posedge clk);
            #1;
            if (cyc == start) begin
                checkOutput("sram_addr_lo", 32'(sram_addr), e.half_base);
                if (!rd) begin
                    checkOutput("dq_out_lo", 32'(sram_dq_out), 32'(data[15:0]));
                    checkOutput("we_n_first", 32'(sram_we_n), 32'd0);
                end
            end
            if (cyc == start + WAIT_CYCLES) begin
                checkOutput("sram_addr_hi", 32'(sram_addr), e.half_base + 1);
                if (!rd) checkOutput("dq_out_hi", 32'(sram_dq_out), 32'(data[31:16]));
            end
        end
    endtask

    task automatic resetMidWrite(input logic [31:0] addr, input logic [31:0] data);
        int unsigned issue;
        mem_r_en   = 1'b0;
        mem_w_en   = 1'b1;
        address    = addr;
        write_data = data;
        issue      = cyc;
        while (cyc < issue + 6) begin
            @(posedge clk);
            #1;
        end
        checkOutput("we_n_before_reset", 32'(sram_we_n), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_ready", 32'(ready), 32'd0);
        checkOutput("rst_freeze_req", 32'(freeze), 32'd1);
        checkOutput("rst_we_n", 32'(sram_we_n), 32'd1);
        checkOutput("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        checkOutput("rst_read_data", read_data, 32'd0);
        last_read = '0;
        we_low    = 0;
        oe_high   = 0;
        mem_w_en  = 1'b0;
        #1;
        checkOutput("rst_freeze_idle", 32'(freeze), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
    endtask

    initial begin
        bit          rd;
        bit          wr;
        bit          b2b;
        logic [31:0] addr;
        for (int i = 0; i < HALVES; i++) sram_mem[i] = init_half(i);
        sram_mem[2] = 16'hBEEF;
        sram_mem[3] = 16'hDEAD;
        ref_mem[1]  = 32'hDEADBEEF;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("init_ready", 32'(ready), 32'd0);
        checkOutput("init_freeze", 32'(freeze), 32'd0);
        checkOutput("init_we_n", 32'(sram_we_n), 32'd1);
        checkOutput("init_dq_oe", 32'(sram_dq_oe), 32'd0);
        checkOutput("init_read_data", read_data, 32'd0);
        checkOutput("init_sram_addr", 32'(sram_addr), 32'd0);
        rst_n = 1'b1;
        idle(1);

        $display("[TB] directed accesses");
        applyStimulus(1'b1, 1'b0, 32'd1028, 32'd0, 1'b0);
        idle(2);
        applyStimulus(1'b0, 1'b1, 32'd1032, 32'h12345678, 1'b0);
        idle(1);
        applyStimulus(1'b0, 1'b1, 32'd1024, 32'hCAFEF00D, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd1024, 32'd0, 1'b1);
        idle(1);
        applyStimulus(1'b1, 1'b1, 32'd1032, 32'hFFFF0000, 1'b0);
        idle(1);

        $display("[TB] reset during write");
        resetMidWrite(32'd1040, 32'h0BADF00D);
        applyStimulus(1'b0, 1'b1, 32'd1040, 32'h0BADF00D, 1'b0);
        idle(1);
        applyStimulus(1'b1, 1'b0, 32'd1040, 32'd0, 1'b0);

        $display("[TB] random accesses");
        for (int i = 0; i < 40; i++) begin
            rd  = ($urandom_range(0, 1) == 1);
            wr  = rd ? ($urandom_range(0, 3) == 0) : 1'b1;
            b2b = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) addr = $urandom;
            else addr = 32'd1024 + 4 * $urandom_range(0, 31) + $urandom_range(0, 3);
            if (!b2b) idle(1 + $urandom_range(0, 2));
            applyStimulus(rd, wr, addr, $urandom, b2b);
        end
        idle(3);
        checkOutput("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
